// File: rtl/ahb_sram_if.sv
// ahb_sram_if
// AHB-Lite slave bridging a 32-bit bus onto an 8 KB SRAM core built as two
// banks of four byte lanes. Reads are issued combinationally in the address
// phase, so read data arrives in the data phase with no wait states. Writes
// are captured in the address phase and performed in the data phase. A read
// that directly follows a write would need the SRAM port in the same cycle
// as that write, so it costs exactly one wait state.
//
// Ports
//   hclk, hresetn           clock, asynchronous active-low reset
//   hsel .. hready          AHB-Lite slave inputs (hready is the bus-level ready)
//   hready_resp, hresp      slave ready and response (always OKAY)
//   hrdata                  read data, zero outside a read data phase
//   sram_we, sram_addr      SRAM write strobe and word address {00, bank, row}
//   sram_wdata              SRAM write data (straight from hwdata)
//   bank0_csn, bank1_csn    active-low byte-lane selects per bank
//   sram_q0 .. sram_q7      SRAM read lanes, q0..q3 bank0, q4..q7 bank1
//
// state    | meaning
// ST_IDLE  | no write pending; reads are served directly from the address phase
// ST_WR    | write data phase; registered write drives the SRAM this cycle
// ST_STALL | write finished, held read address now issued to the SRAM
module ahb_sram_if (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hready_resp,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic        sram_we,
    output logic [12:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic [3:0]  bank0_csn,
    output logic [3:0]  bank1_csn,
    input  logic [7:0]  sram_q0,
    input  logic [7:0]  sram_q1,
    input  logic [7:0]  sram_q2,
    input  logic [7:0]  sram_q3,
    input  logic [7:0]  sram_q4,
    input  logic [7:0]  sram_q5,
    input  logic [7:0]  sram_q6,
    input  logic [7:0]  sram_q7
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_STALL} state_t;

    state_t      state_q, state_d;
    logic [10:0] wr_addr_q, wr_addr_d;    // {bank, row} of the pending write
    logic [3:0]  wr_lanes_q, wr_lanes_d;
    logic        rd_phase_q, rd_phase_d;
    logic        rd_bank_q, rd_bank_d;

    logic        xfer_req;
    logic        valid;
    logic        do_wr;
    logic        do_rd;
    logic [3:0]  lane_en;
    logic        unused_haddr_hi;

    assign xfer_req        = hsel & htrans[1];
    assign valid           = xfer_req & hready;
    assign unused_haddr_hi = ^haddr[31:13];

    always_comb begin
        lane_en = 4'hF;
        case (hsize)
            3'd0:    lane_en = 4'b0001 << haddr[1:0];
            3'd1:    lane_en = haddr[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'hF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_lanes_d  = wr_lanes_q;
        rd_phase_d  = 1'b0;
        rd_bank_d   = rd_bank_q;
        hready_resp = 1'b1;
        do_wr       = 1'b0;
        do_rd       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    if (hwrite) begin
                        state_d    = ST_WR;
                        wr_addr_d  = haddr[12:2];
                        wr_lanes_d = lane_en;
                    end else begin
                        do_rd = 1'b1;
                    end
                end
            end
            ST_WR: begin
                do_wr = 1'b1;
                // This cycle is our own data phase, so the bus hready is our
                // hready_resp; qualifying the conflict with it would loop.
                if (xfer_req && !hwrite) begin
                    hready_resp = 1'b0;
                    state_d     = ST_STALL;
                end else if (valid && hwrite) begin
                    wr_addr_d  = haddr[12:2];
                    wr_lanes_d = lane_en;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                // The master is still holding the read address from the wait cycle.
                do_rd   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_rd) begin
            rd_phase_d = 1'b1;
            rd_bank_d  = haddr[12];
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            wr_lanes_q <= '0;
            rd_phase_q <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_lanes_q <= wr_lanes_d;
            rd_phase_q <= rd_phase_d;
            rd_bank_q  <= rd_bank_d;
        end
    end

    // The read path is combinational from the bus inputs, so it is gated by
    // hresetn to keep the SRAM deselected while reset is held.
    always_comb begin
        bank0_csn = 4'hF;
        bank1_csn = 4'hF;
        sram_we   = 1'b0;
        sram_addr = '0;
        if (hresetn) begin
            if (do_wr) begin
                sram_we   = 1'b1;
                sram_addr = {2'b00, wr_addr_q};
                if (wr_addr_q[10]) bank1_csn = ~wr_lanes_q;
                else               bank0_csn = ~wr_lanes_q;
            end else if (do_rd) begin
                sram_addr = {2'b00, haddr[12:2]};
                if (haddr[12]) bank1_csn = 4'h0;
                else           bank0_csn = 4'h0;
            end
        end
    end

    assign sram_wdata = hwdata;
    assign hresp      = 2'b00;
    assign hrdata     = !rd_phase_q ? 32'h0 :
                        rd_bank_q   ? {sram_q7, sram_q6, sram_q5, sram_q4}
                                    : {sram_q3, sram_q2, sram_q1, sram_q0};

endmodule

// File: tb/tb_ahb_sram_if.sv
// Testbench for ahb_sram_if: AHB-Lite master driving a transfer queue, a
// behavioural SRAM core on the memory side, and a byte-array reference of the
// memory contents used to predict every cycle's outputs.
module tb_ahb_sram_if;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        sram_we;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  bank0_csn;
    logic [3:0]  bank1_csn;
    logic [7:0]  sq [8];

    always #5 hclk = ~hclk;
    assign hready = hready_resp;

    ahb_sram_if dut (
        .hclk(hclk), .hresetn(hresetn),
        .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .haddr(haddr), .hwdata(hwdata), .hready(hready),
        .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .bank0_csn(bank0_csn), .bank1_csn(bank1_csn),
        .sram_q0(sq[0]), .sram_q1(sq[1]), .sram_q2(sq[2]), .sram_q3(sq[3]),
        .sram_q4(sq[4]), .sram_q5(sq[5]), .sram_q6(sq[6]), .sram_q7(sq[7])
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        int          cyc;
        logic [3:0]  b0;
        logic [3:0]  b1;
        logic [12:0] addr;
        logic [31:0] data;
    } log_t;

    xfer_t xq[$];
    log_t  wr_log[$];
    log_t  rd_log[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_stall     = 0;
    int n_active    = 0;

    logic [7:0] sram_mem [8192] = '{default: 8'h00};
    logic [7:0] ref_mem  [8192] = '{default: 8'h00};

    // Behavioural SRAM core: synchronous, one registered read lane per byte.
    always @(posedge hclk) begin
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < 4; l++) begin
                logic [12:0] idx;
                logic        sel_n;
                idx   = {b[0], sram_addr[9:0], l[1:0]};
                sel_n = (b == 0) ? bank0_csn[l] : bank1_csn[l];
                if (!sel_n) begin
                    if (sram_we) sram_mem[idx] <= sram_wdata[8*l +: 8];
                    else         sq[b*4+l]     <= sram_mem[idx];
                end
            end
        end
    end

    function automatic logic [3:0] lane_mask(logic [2:0] sz, logic [1:0] a);
        if (sz == 3'd0) return 4'b0001 << a;
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] a);
        return {ref_mem[{a[12:2], 2'd3}], ref_mem[{a[12:2], 2'd2}],
                ref_mem[{a[12:2], 2'd1}], ref_mem[{a[12:2], 2'd0}]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle reference: decide which SRAM operation the cycle must carry
    // from the transfer history, then compare every output.
    initial begin : compare
        logic        req, e_rdy, e_we, op_rd, op_wr, rd_pend, wr_pend;
        logic [3:0]  e_b0, e_b1, lanes;
        logic [12:0] e_addr;
        logic [31:0] e_rdata, rd_word, wr_addr;
        logic [2:0]  wr_size;
        rd_pend = 1'b0; wr_pend = 1'b0; rd_word = '0; wr_addr = '0; wr_size = '0;
        forever begin
            @(negedge hclk);
            cyc++;
            req     = hsel && htrans[1];
            e_rdy   = 1'b1;
            e_we    = 1'b0;
            e_b0    = 4'hF;
            e_b1    = 4'hF;
            e_addr  = '0;
            e_rdata = rd_pend ? rd_word : 32'h0;
            op_rd   = 1'b0;
            op_wr   = 1'b0;
            lanes   = lane_mask(wr_size, wr_addr[1:0]);
            if (!hresetn) begin
                e_rdata = 32'h0;
            end else if (wr_pend) begin
                op_wr  = 1'b1;
                e_we   = 1'b1;
                e_addr = {2'b00, wr_addr[12:2]};
                if (wr_addr[12]) e_b1 = ~lanes; else e_b0 = ~lanes;
                if (req && !hwrite) e_rdy = 1'b0;
            end else if (req && !hwrite) begin
                op_rd  = 1'b1;
                e_addr = {2'b00, haddr[12:2]};
                if (haddr[12]) e_b1 = 4'h0; else e_b0 = 4'h0;
            end
            vectors++;
            if ({hready_resp, hresp, bank0_csn, bank1_csn, sram_we, sram_addr, hrdata} !==
                {e_rdy, 2'b00, e_b0, e_b1, e_we, e_addr, e_rdata} ||
                (op_wr && sram_wdata !== hwdata)) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got rdy=%b resp=%b csn0=%h csn1=%h we=%b addr=%h rdata=%h wdata=%h, expected rdy=%b resp=00 csn0=%h csn1=%h we=%b addr=%h rdata=%h wdata=%h",
                         cyc, hready_resp, hresp, bank0_csn, bank1_csn, sram_we, sram_addr, hrdata, sram_wdata,
                         e_rdy, e_b0, e_b1, e_we, e_addr, e_rdata, hwdata);
            end
            if (!hready_resp) n_stall++;
            if (bank0_csn != 4'hF || bank1_csn != 4'hF) n_active++;
            if (hresetn) begin
                if (op_wr) begin
                    for (int l = 0; l < 4; l++)
                        if (lanes[l]) ref_mem[{wr_addr[12:2], l[1:0]}] = hwdata[8*l +: 8];
                    wr_log.push_back('{cyc, bank0_csn, bank1_csn, sram_addr, hwdata});
                end
                if (rd_pend) rd_log.push_back('{cyc, bank0_csn, bank1_csn, sram_addr, hrdata});
                rd_pend = op_rd;
                if (op_rd) rd_word = ref_word(haddr);
                if (req && hwrite && e_rdy) begin
                    wr_pend = 1'b1;
                    wr_addr = haddr;
                    wr_size = hsize;
                end else begin
                    wr_pend = 1'b0;
                end
            end else begin
                rd_pend = 1'b0;
                wr_pend = 1'b0;
            end
        end
    end

    task automatic push(logic wr, logic [2:0] sz, logic [31:0] a, logic [31:0] d,
                        logic sel = 1'b1, logic [1:0] tr = 2'b10);
        xfer_t t;
        t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz; t.addr = a; t.data = d;
        xq.push_back(t);
    endtask

    task automatic push_idle();
        push(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 2'b00);
    endtask

    // Presents each queued address phase, holds it while hready_resp is low,
    // and supplies write data in the following data phase.
    task automatic run_queue();
        xfer_t       t;
        logic [31:0] wd;
        logic        rdy;
        int          guard;
        wd = $urandom;
        while (xq.size() != 0) begin
            t      = xq.pop_front();
            hsel   = t.sel;
            htrans = t.trans;
            hwrite = t.wr;
            hsize  = t.size;
            haddr  = t.addr;
            hwdata = wd;
            guard  = 0;
            do begin
                @(negedge hclk);
                rdy = hready_resp;
                @(posedge hclk);
                #1;
                guard++;
            end while (!rdy && guard < 4);
            if (!rdy) chk("hready_timeout", 32'(rdy), 32'h1);
            wd = (t.sel && t.trans[1] && t.wr) ? t.data : $urandom;
        end
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        repeat (2) begin
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int    n0, r0, s0, a0;
        xfer_t t;
        hresetn = 1'b0;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        haddr = 32'h10; hwdata = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hready", 32'(hready_resp), 32'h1);
        chk("rst_hresp", 32'(hresp), 32'h0);
        chk("rst_csn0", 32'(bank0_csn), 32'hF);
        chk("rst_csn1", 32'(bank1_csn), 32'hF);
        chk("rst_we", 32'(sram_we), 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        hresetn = 1'b1;
        hsel = 1'b0; htrans = 2'b00;
        @(posedge hclk);
        #1;

        // word write then read after an idle cycle
        n0 = wr_log.size(); r0 = rd_log.size(); s0 = n_stall;
        push(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        push_idle();
        push(1'b0, 3'd2, 32'h0000_0010, 32'h0);
        run_queue();
        chk("w10_csn0", 32'(wr_log[n0].b0), 32'h0);
        chk("w10_csn1", 32'(wr_log[n0].b1), 32'hF);
        chk("w10_addr", 32'(wr_log[n0].addr), 32'h004);
        chk("r10_data", rd_log[r0].data, 32'hDEAD_BEEF);
        chk("r10_stalls", 32'(n_stall - s0), 32'h0);

        // byte write into bank1 lane 3, word read back
        n0 = wr_log.size(); r0 = rd_log.size();
        push(1'b1, 3'd0, 32'h0000_1003, 32'hAA00_0000);
        push_idle();
        push(1'b0, 3'd2, 32'h0000_1000, 32'h0);
        run_queue();
        chk("b1003_csn1", 32'(wr_log[n0].b1), 32'h7);
        chk("b1003_csn0", 32'(wr_log[n0].b0), 32'hF);
        chk("b1003_addr", 32'(wr_log[n0].addr), 32'h400);
        chk("r1000_lane3", 32'(rd_log[r0].data[31:24]), 32'hAA);

        // write immediately followed by read of the same word
        r0 = rd_log.size(); s0 = n_stall;
        push(1'b1, 3'd2, 32'h0000_0020, 32'h1234_5678);
        push(1'b0, 3'd2, 32'h0000_0020, 32'h0);
        run_queue();
        chk("wr_rd_stalls", 32'(n_stall - s0), 32'h1);
        chk("r20_data", rd_log[r0].data, 32'h1234_5678);

        // four back-to-back writes across both banks
        n0 = wr_log.size(); s0 = n_stall;
        push(1'b1, 3'd2, 32'h0000_0000, 32'h0101_0101);
        push(1'b1, 3'd2, 32'h0000_0004, 32'h0202_0202);
        push(1'b1, 3'd2, 32'h0000_1000, 32'h0303_0303);
        push(1'b1, 3'd2, 32'h0000_1004, 32'h0404_0404);
        run_queue();
        chk("b2b_stalls", 32'(n_stall - s0), 32'h0);
        chk("b2b_w0_csn0", 32'(wr_log[n0].b0), 32'h0);
        chk("b2b_w1_addr", 32'(wr_log[n0+1].addr), 32'h001);
        chk("b2b_w2_csn1", 32'(wr_log[n0+2].b1), 32'h0);
        chk("b2b_w3_addr", 32'(wr_log[n0+3].addr), 32'h401);
        chk("b2b_spacing", 32'(wr_log[n0+3].cyc - wr_log[n0].cyc), 32'h3);

        // BUSY while selected, NONSEQ while deselected
        a0 = n_active; s0 = n_stall;
        push(1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b1, 2'b01);
        push(1'b1, 3'd2, 32'h0000_0014, 32'h5555_5555, 1'b0, 2'b10);
        push(1'b0, 3'd2, 32'h0000_0018, 32'h0, 1'b0, 2'b10);
        run_queue();
        chk("noxfer_active", 32'(n_active - a0), 32'h0);
        chk("noxfer_stalls", 32'(n_stall - s0), 32'h0);

        // reset during a write data phase
        push(1'b1, 3'd2, 32'h0000_0040, 32'h1111_1111);
        run_queue();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h2222_2222;
        chk("pre_rst_we", 32'(sram_we), 32'h1);
        #2;
        hresetn = 1'b0;
        #1;
        chk("abort_csn0", 32'(bank0_csn), 32'hF);
        chk("abort_we", 32'(sram_we), 32'h0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        r0 = rd_log.size();
        push(1'b0, 3'd2, 32'h0000_0040, 32'h0);
        run_queue();
        chk("r40_after_abort", rd_log[r0].data, 32'h1111_1111);

        // randomized mix over a small window of both banks, upper address bits random
        for (int i = 0; i < 400; i++) begin
            t.sel   = ($urandom_range(0, 9) != 0);
            t.trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1))
                                                   : 2'($urandom_range(2, 3));
            t.wr    = 1'($urandom_range(0, 1));
            t.size  = 3'($urandom_range(0, 4));
            t.addr  = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 1)) << 12)
                    | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            t.data  = $urandom;
            xq.push_back(t);
        end
        run_queue();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_sram_if.md
AHB_SRAM_IF -- requirements
Module: ahb_sram_if

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: hclk  in  1  rising-edge clock; hresetn  in  1  async active-low reset.
REQ-002 SHALL have AHB-Lite slave inputs: hsel 1; htrans 2; hwrite 1; hsize 3; haddr 32; hwdata 32; hready 1 (bus-level ready).
REQ-003 SHALL have AHB outputs: hready_resp  out  1  slave ready; hresp  out  2  response; hrdata  out  32  read data.
REQ-004 SHALL drive the memory core with sram_we  out  1 (1 = write), sram_addr  out  13, sram_wdata  out  32, bank0_csn  out  4 and bank1_csn  out  4 (active-low byte-lane selects).
REQ-005 SHALL accept the memory core's read lanes sram_q0..sram_q7  in  8 each (q0..q3 bank0 lanes 0..3, q4..q7 bank1 lanes 0..3).

Function
REQ-006 Valid transfer SHALL be: hsel & htrans[1] & hready; IDLE/BUSY or hsel=0 SHALL cause no SRAM access and a zero-wait OKAY.
REQ-007 Address map SHALL be: bank = haddr[12], row = haddr[11:2], sram_addr = {2'b00, haddr[12:2]}; haddr[31:13] ignored (wraps within 8 KB).
REQ-008 Lane enables SHALL derive from hsize/haddr[1:0]: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0} and {haddr[1],1}; word or hsize>2 -> all four lanes.
REQ-009 Reads SHALL assert the selected bank's four csn lanes low combinationally during the read address phase with sram_we=0, so read data is valid in the following (data-phase) cycle.
REQ-010 hrdata SHALL equal {q3,q2,q1,q0} or {q7,q6,q5,q4} by a registered bank bit captured at the read address phase; hrdata = 0 outside a read data phase.
REQ-011 Writes SHALL register bank, row and lane enables at the address phase and drive them with sram_we=1 in the data phase; sram_wdata = hwdata.
REQ-012 Controller SHALL use a 3-state FSM: IDLE (no pending write), WR (write data phase in progress), STALL (write done, held read being issued).
REQ-013 IDLE -> WR on valid write; WR -> WR on back-to-back valid write with zero wait, the new address phase registered while the old write executes.
REQ-014 WR with a valid read address phase (SRAM port conflict) SHALL execute the write, drive hready_resp=0 for exactly one cycle, and go to STALL.
REQ-015 In STALL SHALL issue the read using the held haddr, drive hready_resp=1, and go to IDLE; the read data phase follows with zero wait.
REQ-016 WR with no valid transfer SHALL go to IDLE after the write.
REQ-017 When idle or the unselected bank, csn lanes SHALL be 4'hF; both banks SHALL never be selected in the same cycle.
REQ-018 hresp SHALL be 2'b00 (OKAY) always; no ERROR responses.
REQ-019 hready_resp SHALL be 1 in every cycle other than the REQ-014 stall cycle.

Reset
REQ-020 On hresetn=0 SHALL asynchronously: state=IDLE, hready_resp=1, hresp=00, bank0_csn=bank1_csn=4'hF, sram_we=0, sram_addr=0, hrdata=0, pending write discarded.
REQ-021 Reset asserted mid-write SHALL abort the write (csn forced high immediately); first post-reset transfer SHALL behave as from IDLE.

Verification
REQ-022 Word write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> bank0_csn=4'h0, sram_addr=13'h004, hrdata=0xDEADBEEF, zero waits.
REQ-023 Byte write 0xAA at 0x1003 (hsize=0) -> bank1_csn=4'b0111, sram_addr=13'h400; later word read 0x1000 returns 0xAA in hrdata[31:24].
REQ-024 Write 0x12345678 @0x20 immediately followed by read @0x20 -> one cycle hready_resp=0, then hrdata=0x12345678.
REQ-025 Four back-to-back word writes 0x0,0x4,0x1000,0x1004 -> no wait states, each csn pattern one cycle after its address phase.
REQ-026 hresetn low during WR data phase -> csn=4'hF and sram_we=0 at once; read of that address after reset returns pre-write value.
REQ-027 htrans=BUSY with hsel=1, and htrans=NONSEQ with hsel=0 -> csn stay 4'hF, hready_resp=1, hresp=00.
